// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_stage
// Brief  : MEM pipeline stage. Runs loads/stores over a req/ready data-memory
//          handshake and stalls upstream until the access completes.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [1:0]    WB_ex,
    input  logic [DW-1:0] ALUResult_ex,
    input  logic [DW-1:0] wdata_ex,
    input  logic [RW-1:0] d_addr_ex,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ready,
    input  logic [DW-1:0] dmem_rdata,
    output logic [1:0]    WB_in,
    output logic [DW-1:0] dmem_rdata_in,
    output logic [DW-1:0] ALUResult_in,
    output logic [RW-1:0] d_addr_in,
    output logic          stall,
    output logic          mem_err,
    output logic [31:0]   stall_cnt
);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_REQ        = 2'd1;
    localparam logic [1:0] c_DONE       = 2'd2;
    localparam bit         c_TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [7:0] c_WAIT_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [7:0]    r_wait_cnt;
    logic          r_we;
    logic          r_err;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_wb;
    logic [RW-1:0] r_daddr;
    logic [31:0]   r_stall_cnt;
    logic          w_mem_op;
    logic          w_timeout;
    logic          w_stall;

    assign w_mem_op  = MemRead | MemWrite;
    // A ready on the last allowed cycle still wins over the timeout.
    assign w_timeout = c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LAST) && !dmem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_stall       = 1'b0;
        WB_in         = WB_ex;
        dmem_rdata_in = '0;
        ALUResult_in  = ALUResult_ex;
        d_addr_in     = d_addr_ex;
        case (r_state)
            c_IDLE: begin
                if (w_mem_op) begin
                    w_stall      = 1'b1;
                    WB_in        = 2'b00;
                    w_next_state = c_REQ;
                end
            end
            c_REQ: begin
                w_stall      = 1'b1;
                WB_in        = 2'b00;
                ALUResult_in = r_addr;
                d_addr_in    = r_daddr;
                if (dmem_ready || w_timeout) begin
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                WB_in         = r_wb;
                dmem_rdata_in = r_rdata;
                ALUResult_in  = r_addr;
                d_addr_in     = r_daddr;
                w_next_state  = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_wb        <= '0;
            r_daddr     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_mem_op) begin
                        r_addr     <= ALUResult_ex;
                        r_wdata    <= wdata_ex;
                        r_we       <= MemWrite;
                        r_wb       <= WB_ex;
                        r_daddr    <= d_addr_ex;
                        r_wait_cnt <= '0;
                    end
                end
                c_REQ: begin
                    if (dmem_ready) begin
                        r_rdata <= r_we ? '0 : dmem_rdata;
                    end else if (w_timeout) begin
                        // Squash the writeback so a failed load cannot update the register file.
                        r_err   <= 1'b1;
                        r_wb    <= 2'b00;
                        r_rdata <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dmem_req   = (r_state == c_REQ);
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign stall      = w_stall;
    assign mem_err    = r_err;
    assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_stage
// Brief  : Self-checking bench for mem_stage (directed table plus random ops).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int DW       = 32;
    localparam int RW       = 5;
    localparam int TO_MAIN  = 255;
    localparam int TO_SHORT = 4;

    typedef struct {
        logic          mr;
        logic          mw;
        logic [1:0]    wb;
        logic [DW-1:0] alu;
        logic [DW-1:0] wdata;
        logic [RW-1:0] dreg;
        int            delay;
        logic [DW-1:0] rdata;
        logic [1:0]    exp_wb;
        logic [DW-1:0] exp_rdata;
        int            exp_stalls;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemRead, MemWrite;
    logic [1:0]    WB_ex;
    logic [DW-1:0] ALUResult_ex, wdata_ex;
    logic [RW-1:0] d_addr_ex;
    logic          dmem_ready, ready_t;
    logic [DW-1:0] dmem_rdata;

    logic          dmem_req, dmem_we, stall, mem_err;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata_in, ALUResult_in;
    logic [1:0]    WB_in;
    logic [RW-1:0] d_addr_in;
    logic [31:0]   stall_cnt;

    logic          req_t, we_t, stall_t, err_t;
    logic [DW-1:0] addr_t, wdata_t, rdata_in_t, alu_in_t;
    logic [1:0]    wb_in_t;
    logic [RW-1:0] daddr_in_t;
    logic [31:0]   cnt_t;

    int            total = 0;
    int            bad   = 0;
    int            exp_cnt = 0;
    vec_t          tbl[7];

    always #5 clk = ~clk;

    mem_stage #(.DW(DW), .RW(RW), .TIMEOUT(TO_MAIN)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .WB_ex(WB_ex), .ALUResult_ex(ALUResult_ex), .wdata_ex(wdata_ex), .d_addr_ex(d_addr_ex),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .WB_in(WB_in), .dmem_rdata_in(dmem_rdata_in), .ALUResult_in(ALUResult_in),
        .d_addr_in(d_addr_in), .stall(stall), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    // Second instance with a short timeout and a memory that never answers.
    mem_stage #(.DW(DW), .RW(RW), .TIMEOUT(TO_SHORT)) dut_t (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .WB_ex(WB_ex), .ALUResult_ex(ALUResult_ex), .wdata_ex(wdata_ex), .d_addr_ex(d_addr_ex),
        .dmem_req(req_t), .dmem_we(we_t), .dmem_addr(addr_t), .dmem_wdata(wdata_t),
        .dmem_ready(ready_t), .dmem_rdata(dmem_rdata),
        .WB_in(wb_in_t), .dmem_rdata_in(rdata_in_t), .ALUResult_in(alu_in_t),
        .d_addr_in(daddr_in_t), .stall(stall_t), .mem_err(err_t), .stall_cnt(cnt_t)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: one issue cycle, N request cycles, then a done cycle.
    function automatic vec_t model(input vec_t v, input int tmo);
        vec_t r;
        int   n;
        bit   err;
        r = v;
        if (v.mr || v.mw) begin
            err = (tmo != 0) && (v.delay >= tmo);
            n   = err ? tmo : v.delay + 1;
            r.exp_stalls = 1 + n;
            r.exp_wb     = err ? 2'b00 : v.wb;
            r.exp_rdata  = (err || v.mw) ? '0 : v.rdata;
        end else begin
            r.exp_stalls = 0;
            r.exp_wb     = v.wb;
            r.exp_rdata  = '0;
        end
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the op's last cycle.
    task automatic do_op(input vec_t v, input bit chk_t);
        MemRead      = v.mr;
        MemWrite     = v.mw;
        WB_ex        = v.wb;
        ALUResult_ex = v.alu;
        wdata_ex     = v.wdata;
        d_addr_ex    = v.dreg;
        if (!(v.mr || v.mw)) begin
            dmem_ready = 1'b1;
            dmem_rdata = $urandom;
            @(negedge clk);
            chk("alu_stall", 32'(stall), 32'd0);
            chk("alu_wb", 32'(WB_in), 32'(v.exp_wb));
            chk("alu_result", ALUResult_in, v.alu);
            chk("alu_daddr", 32'(d_addr_in), 32'(v.dreg));
            chk("alu_rdata", dmem_rdata_in, 32'd0);
            chk("alu_req", 32'(dmem_req), 32'd0);
            chk("alu_cnt", stall_cnt, 32'(exp_cnt));
            @(posedge clk);
            #1;
        end else begin
            for (int k = 0; k <= v.exp_stalls && k < 400; k++) begin
                // Ready outside the request window carries garbage and must be ignored.
                dmem_ready = (k == 0) || (k == v.exp_stalls) || (k - 1 == v.delay);
                dmem_rdata = (k >= 1 && k - 1 == v.delay) ? v.rdata : $urandom;
                @(negedge clk);
                if (k < v.exp_stalls) begin
                    chk("op_stall", 32'(stall), 32'd1);
                    chk("op_bubble", 32'(WB_in), 32'd0);
                    if (k == 0) begin
                        chk("issue_req", 32'(dmem_req), 32'd0);
                    end else begin
                        chk("req_high", 32'(dmem_req), 32'd1);
                        chk("req_addr", dmem_addr, v.alu);
                        chk("req_we", 32'(dmem_we), 32'(v.mw));
                        chk("req_wdata", dmem_wdata, v.wdata);
                    end
                end else begin
                    chk("done_stall", 32'(stall), 32'd0);
                    chk("done_req", 32'(dmem_req), 32'd0);
                    chk("done_wb", 32'(WB_in), 32'(v.exp_wb));
                    chk("done_rdata", dmem_rdata_in, v.exp_rdata);
                    chk("done_alu", ALUResult_in, v.alu);
                    chk("done_daddr", 32'(d_addr_in), 32'(v.dreg));
                    chk("done_cnt", stall_cnt, 32'(exp_cnt + v.exp_stalls));
                    chk("done_err", 32'(mem_err), 32'd0);
                end
                if (chk_t) begin
                    if (k < 1 + TO_SHORT) begin
                        chk("to_stall", 32'(stall_t), 32'd1);
                        if (k >= 1) chk("to_req", 32'(req_t), 32'd1);
                    end else if (k == 1 + TO_SHORT) begin
                        chk("to_done_stall", 32'(stall_t), 32'd0);
                        chk("to_done_req", 32'(req_t), 32'd0);
                        chk("to_done_wb", 32'(wb_in_t), 32'd0);
                        chk("to_done_rdata", rdata_in_t, 32'd0);
                        chk("to_err", 32'(err_t), 32'd1);
                    end
                end
                @(posedge clk);
                #1;
            end
            exp_cnt += v.exp_stalls;
            dmem_ready = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        ready_t      = 1'b0;
        reset        = 1'b1;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        WB_ex        = 2'b00;
        ALUResult_ex = '0;
        wdata_ex     = '0;
        d_addr_ex    = '0;
        dmem_ready   = 1'b0;
        dmem_rdata   = '0;

        tbl[0] = '{1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd3, 0, 32'h0, 2'b10, 32'h0, 0};
        tbl[1] = '{1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd4, 0, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 2};
        tbl[2] = '{1'b0, 1'b1, 2'b01, 32'h80, 32'h55, 5'd0, 4, 32'hBAD0BAD0, 2'b01, 32'h0, 6};
        tbl[3] = '{1'b1, 1'b0, 2'b01, 32'h44, 32'h0, 5'd5, 0, 32'h12345678, 2'b01, 32'h12345678, 2};
        tbl[4] = '{1'b1, 1'b0, 2'b11, 32'h48, 32'h0, 5'd6, 0, 32'h9ABCDEF0, 2'b11, 32'h9ABCDEF0, 2};
        tbl[5] = '{1'b1, 1'b1, 2'b10, 32'h4C, 32'hA5A5A5A5, 5'd7, 0, 32'hDEADBEEF, 2'b10, 32'h0, 2};
        tbl[6] = '{1'b0, 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 5'd31, 0, 32'h0, 2'b01, 32'h0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 0;

        foreach (tbl[i]) do_op(tbl[i], 1'b0);

        // Abort a load with reset during its second request cycle.
        MemRead      = 1'b1;
        MemWrite     = 1'b0;
        WB_ex        = 2'b11;
        ALUResult_ex = 32'h200;
        wdata_ex     = 32'h77;
        d_addr_ex    = 5'd9;
        dmem_ready   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        chk("pre_rst_err_t", 32'(err_t), 32'd1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        @(negedge clk);
        chk("abort_req", 32'(dmem_req), 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_we", 32'(dmem_we), 32'd0);
        chk("abort_addr", dmem_addr, 32'd0);
        chk("abort_wdata", dmem_wdata, 32'd0);
        chk("abort_cnt", stall_cnt, 32'd0);
        chk("abort_rdata", dmem_rdata_in, 32'd0);
        chk("abort_err_t", 32'(err_t), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 0;

        // Timeout on the short-timeout instance; the main instance answers late.
        v = '{1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 5'd7, 5, 32'h0BADCAFE, 2'b00, 32'h0, 0};
        v = model(v, TO_MAIN);
        do_op(v, 1'b1);
        do_op(tbl[0], 1'b0);
        chk("err_sticky", 32'(err_t), 32'd1);

        for (int i = 0; i < 40; i++) begin
            v.mr    = 1'($urandom_range(0, 1));
            v.mw    = 1'($urandom_range(0, 1));
            v.wb    = 2'($urandom_range(0, 3));
            v.alu   = $urandom;
            v.wdata = $urandom;
            v.dreg  = 5'($urandom_range(0, 31));
            v.delay = int'($urandom_range(0, 6));
            v.rdata = $urandom;
            v = model(v, TO_MAIN);
            do_op(v, 1'b0);
        end
        chk("final_err_t", 32'(err_t), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
